// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared constants and types for the write-back port arbiter:
//               zero-register address, grant encoding, FIFO entry record.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

  localparam int WB_WIDTH  = 64;
  localparam int WB_ADDR_W = 5;

  // Register X31 reads as zero; writes to it are dropped at enqueue.
  localparam logic [4:0] XZR_ADDR = 5'd31;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  // One pending register-file write at the default geometry.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_WIDTH-1:0]  data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Bundle of the two requester handshakes, the register-file
//               write port and the busy flag of the write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5
);

  logic              aValid;
  logic              aReady;
  logic [ADDR_W-1:0] aAddr;
  logic [WIDTH-1:0]  aData;

  logic              bValid;
  logic              bReady;
  logic [ADDR_W-1:0] bAddr;
  logic [WIDTH-1:0]  bData;

  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [WIDTH-1:0]  wrData;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  aValid, aAddr, aData,
    input  bValid, bAddr, bData,
    output aReady, bReady,
    output wrEn, wrAddr, wrData, busy
  );

  // Requester / environment side.
  modport master (
    output aValid, aAddr, aData,
    output bValid, bAddr, bData,
    input  aReady, bReady,
    input  wrEn, wrAddr, wrData, busy
  );

endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Small in-order FIFO of pending register writes. Pointers wrap
//               modulo BUF_DEPTH; full/empty come from an occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter int WIDTH     = 64,
  parameter int ADDR_W    = 5,
  parameter int BUF_DEPTH = 2
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              push,
  input  wire logic [ADDR_W-1:0] push_addr,
  input  wire logic [WIDTH-1:0]  push_data,
  input  wire logic              pop,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W-1:0]      head_addr,
  output logic [WIDTH-1:0]       head_data
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(BUF_DEPTH);

  logic [ADDR_W-1:0] addr_mem_q [BUF_DEPTH];
  logic [ADDR_W-1:0] addr_mem_d [BUF_DEPTH];
  logic [WIDTH-1:0]  data_mem_q [BUF_DEPTH];
  logic [WIDTH-1:0]  data_mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full      = (count_q == C_DEPTH);
  assign empty     = (count_q == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_addr = addr_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (do_push) begin
      addr_mem_d[wr_ptr_q] = push_addr;
      data_mem_d[wr_ptr_q] = push_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between the execute
//               result (A) and the load return (B). Each side is buffered in
//               a wb_fifo; a round-robin arbiter drains one entry per cycle
//               into registered wrEn/wrAddr/wrData. Writes to X31 vanish.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int ADDR_W    = 5,
  parameter int BUF_DEPTH = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  wb_port_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] C_XZR = ADDR_W'(XZR_ADDR);

  logic              a_full, a_empty, a_push;
  logic              b_full, b_empty, b_push;
  logic [ADDR_W-1:0] a_head_addr, b_head_addr;
  logic [WIDTH-1:0]  a_head_data, b_head_data;
  logic              grant_a, grant_b;

  grant_t            last_grant_q, last_grant_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;

  // Ready reflects fullness only; a full FIFO stays not-ready while popping.
  assign bus.aReady = !a_full;
  assign bus.bReady = !b_full;

  // Zero-register writes complete the handshake but never enter a FIFO.
  assign a_push = bus.aValid && !a_full && (bus.aAddr != C_XZR);
  assign b_push = bus.bValid && !b_full && (bus.bAddr != C_XZR);

  wb_fifo #(
    .WIDTH     (WIDTH),
    .ADDR_W    (ADDR_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_fifo_a (
    .clk       (clk),
    .reset     (reset),
    .push      (a_push),
    .push_addr (bus.aAddr),
    .push_data (bus.aData),
    .pop       (grant_a),
    .full      (a_full),
    .empty     (a_empty),
    .head_addr (a_head_addr),
    .head_data (a_head_data)
  );

  wb_fifo #(
    .WIDTH     (WIDTH),
    .ADDR_W    (ADDR_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_fifo_b (
    .clk       (clk),
    .reset     (reset),
    .push      (b_push),
    .push_addr (bus.bAddr),
    .push_data (bus.bData),
    .pop       (grant_b),
    .full      (b_full),
    .empty     (b_empty),
    .head_addr (b_head_addr),
    .head_data (b_head_data)
  );

  // Round-robin grant: a lone non-empty FIFO wins; on a tie the side that
  // did not win last time goes.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!a_empty && !b_empty) begin
      if (last_grant_q == GRANT_B) grant_a = 1'b1;
      else                         grant_b = 1'b1;
    end else if (!a_empty) begin
      grant_a = 1'b1;
    end else if (!b_empty) begin
      grant_b = 1'b1;
    end
  end

  // Output register next-state: load the granted head, else hold addr/data.
  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (grant_a) begin
      last_grant_d = GRANT_A;
      wr_en_d      = 1'b1;
      wr_addr_d    = a_head_addr;
      wr_data_d    = a_head_data;
    end else if (grant_b) begin
      last_grant_d = GRANT_B;
      wr_en_d      = 1'b1;
      wr_addr_d    = b_head_addr;
      wr_data_d    = b_head_data;
    end
  end

  // Registered write port and round-robin history; B is "last" after reset
  // so A takes the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= GRANT_B;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.wrEn   = wr_en_q;
  assign bus.wrAddr = wr_addr_q;
  assign bus.wrData = wr_data_q;
  assign bus.busy   = !a_empty || !b_empty || wr_en_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench for wb_port_arbiter: a table of directed
//               per-cycle vectors plus hand-written contention, backpressure
//               and mid-flight reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  typedef struct packed {
    logic        av;
    logic [4:0]  aa;
    logic [63:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [63:0] bd;
    logic        e_ar;
    logic        e_br;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    logic        e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  wb_entry_t log_q[$];
  int        b_block_cycles = 0;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.WIDTH(64), .ADDR_W(5)) bus ();

  wb_port_arbiter #(
    .WIDTH     (64),
    .ADDR_W    (5),
    .BUF_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Record every register-file write and every cycle B is held off.
  always @(negedge clk) begin
    if (bus.wrEn === 1'b1) log_q.push_back('{addr: bus.wrAddr, data: bus.wrData});
    if (bus.bValid && !bus.bReady) b_block_cycles++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_log(input string name, input int start, input wb_entry_t exp[$]);
    check({name, "_count"}, 64'(log_q.size() - start), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (start + i < log_q.size()) begin
        check($sformatf("%s_addr%0d", name, i), 64'(log_q[start+i].addr), 64'(exp[i].addr));
        check($sformatf("%s_data%0d", name, i), log_q[start+i].data, exp[i].data);
      end
    end
  endtask

  task automatic idle();
    bus.aValid = 1'b0;
    bus.bValid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 100; c++) begin
      if (!bus.busy) break;
      @(posedge clk); #1;
    end
    check({name, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic drive_a(input int n, input logic [4:0] addr, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      logic acc;
      int   guard;
      bus.aValid = 1'b1;
      bus.aAddr  = addr;
      bus.aData  = base + 64'(i);
      guard = 0;
      do begin
        acc = bus.aReady;
        @(posedge clk); #1;
        guard++;
      end while (!acc && guard < 50);
      if (!acc) begin
        checks++; errors++;
        $display("FAIL drive_a_timeout: aReady got 0, expected 1 within 50 cycles");
        break;
      end
    end
    bus.aValid = 1'b0;
  endtask

  task automatic drive_b(input int n, input logic [4:0] addr, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      logic acc;
      int   guard;
      bus.bValid = 1'b1;
      bus.bAddr  = addr;
      bus.bData  = base + 64'(i);
      guard = 0;
      do begin
        acc = bus.bReady;
        @(posedge clk); #1;
        guard++;
      end while (!acc && guard < 50);
      if (!acc) begin
        checks++; errors++;
        $display("FAIL drive_b_timeout: bReady got 0, expected 1 within 50 cycles");
        break;
      end
    end
    bus.bValid = 1'b0;
  endtask

  vec_t      vecs[14];
  wb_entry_t exp_q[$];
  int        start;
  int        blk0;

  initial begin
    // Directed per-cycle table: inputs before the edge, outputs after it.
    //           av aa     ad        bv ba     bd     ar br we wa     wd        busy
    vecs[0]  = '{T, 5'd3,  64'hCAFE, F, 5'd0,  64'h0,  T, T, F, 5'd0, 64'h0,    T};
    vecs[1]  = '{F, 5'd0,  64'h0,    F, 5'd0,  64'h0,  T, T, T, 5'd3, 64'hCAFE, T};
    vecs[2]  = '{F, 5'd0,  64'h0,    F, 5'd0,  64'h0,  T, T, F, 5'd3, 64'hCAFE, F};
    vecs[3]  = '{T, 5'd1,  64'h11,   T, 5'd2,  64'h22, T, T, F, 5'd3, 64'hCAFE, T};
    vecs[4]  = '{F, 5'd0,  64'h0,    F, 5'd0,  64'h0,  T, T, T, 5'd2, 64'h22,   T};
    vecs[5]  = '{F, 5'd0,  64'h0,    F, 5'd0,  64'h0,  T, T, T, 5'd1, 64'h11,   T};
    vecs[6]  = '{F, 5'd0,  64'h0,    F, 5'd0,  64'h0,  T, T, F, 5'd1, 64'h11,   F};
    vecs[7]  = '{T, 5'd31, 64'hDEAD, F, 5'd0,  64'h0,  T, T, F, 5'd1, 64'h11,   F};
    vecs[8]  = '{T, 5'd4,  64'h44,   F, 5'd0,  64'h0,  T, T, F, 5'd1, 64'h11,   T};
    vecs[9]  = '{F, 5'd0,  64'h0,    F, 5'd0,  64'h0,  T, T, T, 5'd4, 64'h44,   T};
    vecs[10] = '{F, 5'd0,  64'h0,    F, 5'd0,  64'h0,  T, T, F, 5'd4, 64'h44,   F};
    vecs[11] = '{F, 5'd0,  64'h0,    T, 5'd7,  64'h77, T, T, F, 5'd4, 64'h44,   T};
    vecs[12] = '{F, 5'd0,  64'h0,    F, 5'd0,  64'h0,  T, T, T, 5'd7, 64'h77,   T};
    vecs[13] = '{F, 5'd0,  64'h0,    F, 5'd0,  64'h0,  T, T, F, 5'd7, 64'h77,   F};

    reset = 1'b1;
    bus.aValid = 1'b0; bus.aAddr = '0; bus.aData = '0;
    bus.bValid = 1'b0; bus.bAddr = '0; bus.bData = '0;
    #22 reset = 1'b0;
    @(posedge clk); #1;

    check("reset_wrEn",   64'(bus.wrEn),   64'd0);
    check("reset_wrAddr", 64'(bus.wrAddr), 64'd0);
    check("reset_wrData", bus.wrData,      64'd0);
    check("reset_busy",   64'(bus.busy),   64'd0);
    check("reset_aReady", 64'(bus.aReady), 64'd1);
    check("reset_bReady", 64'(bus.bReady), 64'd1);

    for (int i = 0; i < 14; i++) begin
      bus.aValid = vecs[i].av; bus.aAddr = vecs[i].aa; bus.aData = vecs[i].ad;
      bus.bValid = vecs[i].bv; bus.bAddr = vecs[i].ba; bus.bData = vecs[i].bd;
      @(posedge clk); #1;
      check($sformatf("v%0d_aReady", i), 64'(bus.aReady), 64'(vecs[i].e_ar));
      check($sformatf("v%0d_bReady", i), 64'(bus.bReady), 64'(vecs[i].e_br));
      check($sformatf("v%0d_wrEn",   i), 64'(bus.wrEn),   64'(vecs[i].e_we));
      check($sformatf("v%0d_wrAddr", i), 64'(bus.wrAddr), 64'(vecs[i].e_wa));
      check($sformatf("v%0d_wrData", i), bus.wrData,      vecs[i].e_wd);
      check($sformatf("v%0d_busy",   i), 64'(bus.busy),   64'(vecs[i].e_busy));
    end
    idle();

    // Sustained contention: B won last, so A leads and grants alternate.
    start = log_q.size();
    fork
      drive_a(6, 5'd8,  64'hA0);
      drive_b(6, 5'd16, 64'hB0);
    join
    wait_idle("contend");
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{addr: 5'd8,  data: 64'hA0 + 64'(i)});
      exp_q.push_back('{addr: 5'd16, data: 64'hB0 + 64'(i)});
    end
    compare_log("contend", start, exp_q);

    // Backpressure: B's FIFO fills and holds off B; A drains its tail alone.
    start = log_q.size();
    blk0  = b_block_cycles;
    fork
      drive_a(6, 5'd9,  64'h100);
      drive_b(4, 5'd17, 64'h200);
    join
    wait_idle("bp");
    check("bp_bReady_low", 64'(b_block_cycles > blk0), 64'd1);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{addr: 5'd9,  data: 64'h100 + 64'(i)});
      exp_q.push_back('{addr: 5'd17, data: 64'h200 + 64'(i)});
    end
    exp_q.push_back('{addr: 5'd9, data: 64'h104});
    exp_q.push_back('{addr: 5'd9, data: 64'h105});
    compare_log("bp", start, exp_q);

    // Mid-flight reset: load both FIFOs, then reset between edges.
    bus.aValid = 1'b1; bus.aAddr = 5'd12; bus.aData = 64'h55;
    bus.bValid = 1'b1; bus.bAddr = 5'd13; bus.bData = 64'h66;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_wrEn", 64'(bus.wrEn), 64'd1);
    check("rst_pre_busy", 64'(bus.busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_wrEn",   64'(bus.wrEn),   64'd0);
    check("rst_async_busy",   64'(bus.busy),   64'd0);
    check("rst_async_wrAddr", 64'(bus.wrAddr), 64'd0);
    check("rst_async_aReady", 64'(bus.aReady), 64'd1);
    check("rst_async_bReady", 64'(bus.bReady), 64'd1);
    idle();
    @(posedge clk); #3 reset = 1'b0;
    start = log_q.size();
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_stale", 64'(log_q.size() - start), 64'd0);
    check("rst_post_busy", 64'(bus.busy), 64'd0);

    // First tie after reset goes to A.
    start = log_q.size();
    bus.aValid = 1'b1; bus.aAddr = 5'd1; bus.aData = 64'h11;
    bus.bValid = 1'b1; bus.bAddr = 5'd2; bus.bData = 64'h22;
    @(posedge clk); #1;
    idle();
    wait_idle("tie");
    exp_q.delete();
    exp_q.push_back('{addr: 5'd1, data: 64'h11});
    exp_q.push_back('{addr: 5'd2, data: 64'h22});
    compare_log("tie", start, exp_q);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the register file's single write port between two write-back requesters: A (ALU/execute result) and B (memory load return). Each requester has a small in-order FIFO with valid/ready handshake. A round-robin arbiter drains one entry per cycle into registered wrEn/wrAddr/wrData outputs, which drive the register file write port directly. Writes to X31 (zero register) are accepted and silently discarded.

Parameters:
WIDTH, 64, data width of a write
ADDR_W, 5, register address width
BUF_DEPTH, 2, entries per requester FIFO (power of 2, >= 2)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
aValid  input  1  requester A presents a write
aReady  output  1  A FIFO can accept (= !aFull)
aAddr  input  ADDR_W  A destination register
aData  input  WIDTH  A write data
bValid  input  1  requester B presents a write
bReady  output  1  B FIFO can accept (= !bFull)
bAddr  input  ADDR_W  B destination register
bData  input  WIDTH  B write data
wrEn  output  1  register file write enable (registered)
wrAddr  output  ADDR_W  register file write address (registered)
wrData  output  WIDTH  register file write data (registered)
busy  output  1  any FIFO non-empty or wrEn high

Behaviour:
- Reset (async, active-high): FIFOs emptied (pointers and counts = 0); wrEn=0, wrAddr=0, wrData=0; lastGrant=B (so A wins the first tie); aReady=bReady=1 once reset is low; busy=0. Reset mid-operation drops all pending entries; none is written after release.
- Handshake: transfer occurs on a posedge where xValid && xReady. aReady and bReady depend only on FIFO fullness, with no same-cycle pop pass-through: a full FIFO holds ready=0 even in a cycle it pops.
- Requester interface is held stable by the requester while valid && !ready; the block does not check this.
- Enqueue filter: a transfer with addr == XZR_ADDR (31) is accepted but not enqueued; the count is unchanged.
- Arbitration (combinational on FIFO heads, each cycle):
  - Only one FIFO non-empty -> grant it.
  - Both non-empty -> grant the one opposite lastGrant; lastGrant updates on every grant.
  - Neither non-empty -> no grant.
- Granted head is popped; wrEn/wrAddr/wrData load from it at the same posedge. With no grant, wrEn loads 0 and wrAddr/wrData hold their previous values.
- Latency: a transfer accepted at edge N appears as wrEn=1 during the cycle after edge N+1, provided its FIFO was empty and no contention. wrEn is high for exactly one cycle per write.
- Throughput: one write per cycle total. Under continuous contention each requester receives 1/2 of the slots.
- Ordering:
  - FIFO order is preserved within a requester.
  - No ordering is guaranteed between A and B, including for the same address; the hazard unit upstream owns that.
- Simultaneous push and pop on the same FIFO (non-full) is legal; count is unchanged.
- Pointers wrap modulo BUF_DEPTH; full/empty are decided from a count of width clog2(BUF_DEPTH)+1.
- busy = (aCount != 0) | (bCount != 0) | wrEn.

Decomposition:
- Package wb_arb_pkg: localparam XZR_ADDR = 5'd31; typedef enum logic {GRANT_A, GRANT_B} grant_t; typedef of the FIFO entry struct {addr, data}.
- Sub-module wb_fifo (parameterised WIDTH, ADDR_W, BUF_DEPTH): push/pop/full/empty/head ports, async active-high reset. Instantiated twice.
- Arbiter and output register stay in wb_port_arbiter.

Test Plan:
- Single write: A presents addr=3, data=64'hCAFE, accepted at edge 1 -> wrEn=1, wrAddr=3, wrData=64'hCAFE in the cycle after edge 2 only; busy returns to 0 afterwards.
- Tie: A (addr=1, 64'h11) and B (addr=2, 64'h22) accepted at the same edge after reset -> consecutive cycles write reg1=0x11, then reg2=0x22.
- Sustained contention: both valid for 6 cycles with incrementing data -> write sequence alternates A,B,A,B..., no drops, each requester's data arrives in its issue order.
- Backpressure: B streams 4 writes back-to-back while A streams continuously -> bReady falls to 0 after B's FIFO holds 2 entries; all 4 B writes eventually appear in order and none is duplicated.
- Zero register: A writes addr=31, data=64'hDEAD -> aReady stays 1 and wrEn never asserts; a following A write to addr=4 keeps the normal 2-edge latency.
- Reset mid-flight: 2 entries pending in each FIFO, reset pulsed asynchronously between edges -> wrEn=0 and busy=0 immediately; no stale writes after release; the next A and B tie grants A.
